// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and counter sizing.
// SERIAL_ADDER_OVF_EN (in serial_adder_ctrl) adds a signed-overflow output.
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

    // Bits needed to count 0..w-1; never less than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_adder_s.sv
// Single-bit full adder cell used as the datapath of the serial adder.
module full_adder_s (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: streams operands LSB-first through one full_adder_s cell.
// Defining SERIAL_ADDER_OVF_EN adds the registered two's-complement overflow output ovf.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state, state_next;

    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-2:0] sh_s;
    logic [WIDTH-1:0] s_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic             load;
    logic             last;

    full_adder_s u_fa (
        .a     (sh_a[0]),
        .b     (sh_b[0]),
        .cin   (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Only the upper WIDTH-1 result bits need storing; the newest bit comes straight from the cell.
    assign s_next = {fa_sum, sh_s};
    assign load   = start && (state != SHIFT);
    assign last   = (state == SHIFT) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? SHIFT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a  <= '0;
            sh_b  <= '0;
            sh_s  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (load) begin
            sh_a  <= a;
            sh_b  <= b;
            sh_s  <= '0;
            carry <= cin;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
            sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
            sh_s  <= s_next[WIDTH-1:1];
            carry <= fa_carry;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= s_next;
                cout <= fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
                // carry still holds the carry into the MSB on the final bit.
                ovf  <= carry ^ fa_carry;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): directed cases plus random operands vs. an arithmetic model.
// Checks ovf as well when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents operands with start high for one edge; returns at the negedge of cycle 1.
    task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        @(negedge clk);
        a     = ta;
        b     = tb;
        cin   = tc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Reference: plain integer addition over the full operand range.
    task automatic checkResult(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        int total;
        int stotal;
        logic [W:0] expv;
        total  = int'(ta) + int'(tb) + int'(tc);
        expv   = total[W:0];
        stotal = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
        checkOutput({tag, ".sum"}, 32'(sum), 32'(expv[W-1:0]));
        checkOutput({tag, ".cout"}, 32'(cout), 32'(expv[W]));
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput({tag, ".ovf"}, 32'(ovf), 32'((stotal > 127) || (stotal < -128)));
`else
        if (stotal > 1000) $display("[TB] unreachable");
`endif
    endtask

    // Full operation with per-cycle busy/done checks; glitch>0 pulses start with other operands in that cycle.
    task automatic runOp(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input int glitch);
        applyStimulus(ta, tb, tc);
        for (int c = 1; c <= W; c++) begin
            if (c == glitch) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'h55;
            end else begin
                start = 1'b0;
            end
            checkOutput({tag, ".busy"}, 32'(busy), 32'(1));
            checkOutput({tag, ".done_early"}, 32'(done), 32'(0));
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput({tag, ".done"}, 32'(done), 32'(1));
        checkOutput({tag, ".busy_at_done"}, 32'(busy), 32'(0));
        checkResult(tag, ta, tb, tc);
        @(negedge clk);
        checkOutput({tag, ".done_pulse"}, 32'(done), 32'(0));
        checkOutput({tag, ".idle_busy"}, 32'(busy), 32'(0));
        checkResult({tag, ".hold"}, ta, tb, tc);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset.busy", 32'(busy), 32'(0));
        checkOutput("reset.done", 32'(done), 32'(0));
        checkOutput("reset.sum", 32'(sum), 32'(0));
        checkOutput("reset.cout", 32'(cout), 32'(0));
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput("reset.ovf", 32'(ovf), 32'(0));
`endif
        rst = 1'b0;

        runOp("basic", 8'h0F, 8'h01, 1'b0, 0);
        runOp("wrap", 8'hFF, 8'h01, 1'b0, 0);
        runOp("sovf", 8'h7F, 8'h01, 1'b1, 0);
        runOp("max", 8'hFF, 8'hFF, 1'b1, 0);
        runOp("zero", 8'h00, 8'h00, 1'b0, 0);
        runOp("ignored_start", 8'h0F, 8'h01, 1'b0, 4);

        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            runOp($sformatf("rand%0d", i), ra, rb, rc, 0);
        end

        // Start held high: done every W+1 cycles, next busy right after each done.
        @(negedge clk);
        a     = 8'h01;
        b     = 8'h02;
        cin   = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 3 * (W + 1); c++) begin
            @(negedge clk);
            if (c == 3 * (W + 1)) start = 1'b0;
            checkOutput($sformatf("b2b.done%0d", c), 32'(done), 32'(c % (W + 1) == 0));
            checkOutput($sformatf("b2b.busy%0d", c), 32'(busy), 32'(c % (W + 1) != 0));
            if (c % (W + 1) == 0) checkResult($sformatf("b2b%0d", c), 8'h01, 8'h02, 1'b0);
        end
        @(negedge clk);
        checkOutput("b2b.end_busy", 32'(busy), 32'(0));
        checkOutput("b2b.end_done", 32'(done), 32'(0));

        // Reset during cycle 5 of an operation aborts it and clears results.
        applyStimulus(8'h33, 8'h44, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort.busy", 32'(busy), 32'(0));
        checkOutput("abort.done", 32'(done), 32'(0));
        checkOutput("abort.sum", 32'(sum), 32'(0));
        checkOutput("abort.cout", 32'(cout), 32'(0));
        for (int c = 0; c < W + 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("abort.nodone%0d", c), 32'(done), 32'(0));
        end

        runOp("after_abort", 8'h80, 8'h80, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
